// File: rtl/detector_jogada_pkg.sv
// Shared game constants: FSM state codes, default debounce length and
// the one-hot test used by the play detector and the debug decoder.
package detector_jogada_pkg;

    localparam int DEBOUNCE_CICLOS_PADRAO = 5;

    typedef enum logic [2:0] {
        ESPERA    = 3'd0,
        FILTRANDO = 3'd1,
        REGISTRA  = 3'd2,
        INVALIDA  = 3'd3,
        SOLTANDO  = 3'd4
    } estado_t;

    // True when exactly one button is pressed.
    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/detector_jogada_contador_debounce.sv
// Saturating stability counter. clear has priority; clear together with
// enable restarts the count at 1, so the cycle that clears the count can
// also count itself as the first stable sample. fim is raised when the
// next enabled edge completes LIMITE samples.
module contador_debounce #(
    parameter int LIMITE = 5,
    parameter int CW     = $clog2(LIMITE + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    logic [CW-1:0] cnt;

    // Count register: restart on clear, saturate at LIMITE.
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= enable ? CW'(1) : '0;
        else if (enable && (cnt != CW'(LIMITE)))
            cnt <= cnt + CW'(1);
    end

    // Terminal flag: this enabled edge reaches LIMITE.
    always_comb fim = (cnt >= CW'(LIMITE - 1));

endmodule

// File: rtl/detector_jogada.sv
// Button play detector: debounces the four player buttons, reports one
// valid one-hot play or one invalid pattern per press, then waits for a
// stable release before arming again.
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = detector_jogada_pkg::DEBOUNCE_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       jogada_invalida,
    output logic [3:0] db_estado
);
    import detector_jogada_pkg::*;

    estado_t    estado, prox;
    logic [3:0] amostra;
    logic       cnt_clr, cnt_en, cnt_fim;
    logic       carrega_amostra, carrega_jogada;

    // One counter serves both press filtering and release filtering.
    contador_debounce #(.LIMITE(DEBOUNCE_CICLOS)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .fim    (cnt_fim)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= ESPERA;
        else       estado <= prox;
    end

    // Next state and datapath strobes.
    always_comb begin
        prox            = estado;
        cnt_clr         = 1'b0;
        cnt_en          = 1'b0;
        carrega_amostra = 1'b0;
        carrega_jogada  = 1'b0;
        case (estado)
            ESPERA: begin
                cnt_clr = 1'b1;
                if (habilita && (botoes != 4'd0)) begin
                    carrega_amostra = 1'b1;
                    cnt_en          = 1'b1;
                    prox            = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (!habilita || (botoes == 4'd0)) begin
                    cnt_clr = 1'b1;
                    prox    = ESPERA;
                end else if (botoes == amostra) begin
                    cnt_en = 1'b1;
                    if (cnt_fim) begin
                        if (eh_one_hot(amostra)) begin
                            carrega_jogada = 1'b1;
                            prox           = REGISTRA;
                        end else begin
                            prox = INVALIDA;
                        end
                    end
                end else begin
                    // Pattern changed while still pressed: restart filtering.
                    carrega_amostra = 1'b1;
                    cnt_clr         = 1'b1;
                    cnt_en          = 1'b1;
                end
            end
            REGISTRA, INVALIDA: begin
                cnt_clr = 1'b1;
                prox    = SOLTANDO;
            end
            SOLTANDO: begin
                if (botoes != 4'd0) begin
                    cnt_clr = 1'b1;
                end else if (cnt_fim) begin
                    cnt_clr = 1'b1;
                    prox    = ESPERA;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                prox    = ESPERA;
            end
        endcase
    end

    // Sample and captured-play registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            amostra <= 4'd0;
            jogada  <= 4'd0;
        end else begin
            if (carrega_amostra) amostra <= botoes;
            if (carrega_jogada)  jogada  <= amostra;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        jogada_feita    = (estado == REGISTRA);
        jogada_invalida = (estado == INVALIDA);
        db_estado       = {1'b0, estado};
    end

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed press scenarios plus random
// bouncing/enable/reset traffic, checked against a run-length model.
module tb_detector_jogada;

    localparam int N = 5;

    logic       clock = 1'b0;
    logic       reset, habilita;
    logic [3:0] botoes;
    logic       jogada_feita, jogada_invalida;
    logic [3:0] jogada, db_estado;

    detector_jogada #(.DEBOUNCE_CICLOS(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .botoes          (botoes),
        .jogada_feita    (jogada_feita),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         inv;
        logic [3:0] val;
        int         ciclo;
    } evento_t;

    evento_t    fila[$];
    int         vetores = 0, erros = 0, ciclo = 0;
    bit         ativo = 0;

    // Reference model: press detection as "N identical non-zero enabled
    // samples in a row", release as "N zero samples in a row", with the
    // one-cycle report slot in between.
    bit         armado = 1, slot = 0;
    int         run_len = 0, zero_run = 0;
    logic [3:0] run_val = 0, exp_jog = 0, exp_estado = 0;

    function automatic bit one_hot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic modelo(input bit r, input bit h, input logic [3:0] b);
        evento_t e;
        if (r) begin
            armado = 1; slot = 0; run_len = 0; zero_run = 0; run_val = 0;
            exp_jog = 0; exp_estado = 0; ativo = 1;
            fila.delete();
            return;
        end
        if (slot) begin
            slot = 0; zero_run = 0; exp_estado = 4;
            return;
        end
        if (!armado) begin
            zero_run = (b == 0) ? zero_run + 1 : 0;
            if (zero_run == N) begin
                armado = 1; run_len = 0; exp_estado = 0;
            end else exp_estado = 4;
            return;
        end
        if (h && b != 0) begin
            if (run_len > 0 && b == run_val) run_len++;
            else begin run_val = b; run_len = 1; end
        end else run_len = 0;
        if (run_len == N) begin
            e.inv = !one_hot(run_val); e.val = run_val; e.ciclo = ciclo;
            fila.push_back(e);
            if (!e.inv) exp_jog = run_val;
            exp_estado = e.inv ? 4'd3 : 4'd2;
            armado = 0; slot = 1;
        end else exp_estado = (run_len > 0) ? 4'd1 : 4'd0;
    endtask

    // One clock of stimulus: drive at negedge, model the rising edge.
    task automatic passo(input bit r, input bit h, input logic [3:0] b);
        @(negedge clock);
        reset = r; habilita = h; botoes = b;
        @(posedge clock);
        ciclo++;
        modelo(r, h, b);
    endtask

    task automatic segura(input bit h, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) passo(0, h, b);
    endtask

    // Monitor: compare outputs each cycle; pulses are matched to the queue.
    always @(negedge clock) begin
        if (ativo) begin
            evento_t e;
            vetores++;
            if (db_estado !== exp_estado) begin
                erros++;
                $display("FAIL db_estado ciclo=%0d got=%0d exp=%0d", ciclo, db_estado, exp_estado);
            end
            vetores++;
            if (jogada !== exp_jog) begin
                erros++;
                $display("FAIL jogada ciclo=%0d got=%b exp=%b", ciclo, jogada, exp_jog);
            end
            vetores++;
            if (jogada_feita === 1'b1 && jogada_invalida === 1'b1) begin
                erros++;
                $display("FAIL pulsos_juntos ciclo=%0d got=11 exp=not both", ciclo);
            end
            if (jogada_feita === 1'b1 || jogada_invalida === 1'b1) begin
                vetores++;
                if (fila.size() == 0) begin
                    erros++;
                    $display("FAIL pulso_extra ciclo=%0d got=feita%b/inv%b exp=none", ciclo, jogada_feita, jogada_invalida);
                end else begin
                    e = fila.pop_front();
                    if (e.ciclo != ciclo || jogada_invalida !== e.inv || (!e.inv && jogada !== e.val)) begin
                        erros++;
                        $display("FAIL pulso ciclo=%0d got=inv%b/%b exp=inv%b/%b@%0d", ciclo, jogada_invalida, jogada, e.inv, e.val, e.ciclo);
                    end
                end
            end else if (fila.size() > 0 && fila[0].ciclo <= ciclo) begin
                vetores++;
                erros++;
                e = fila.pop_front();
                $display("FAIL pulso_faltando ciclo=%0d got=none exp=inv%b/%b", ciclo, e.inv, e.val);
            end
        end
    end

    initial begin
        logic [3:0] v;
        int         n;
        reset = 1; habilita = 0; botoes = 0;
        passo(1, 0, 4'b0000);
        passo(1, 0, 4'b0000);
        passo(0, 1, 4'b0000);
        vetores++;
        if (jogada !== 4'd0 || db_estado !== 4'd0 || jogada_feita !== 1'b0 || jogada_invalida !== 1'b0) begin
            erros++;
            $display("FAIL reset_state got=%b/%0d/%b%b exp=0000/0/00", jogada, db_estado, jogada_feita, jogada_invalida);
        end
        // Clean single press, then release.
        segura(1, 4'b0001, 10);
        segura(1, 4'b0000, 8);
        // Bouncing before a stable press.
        for (int i = 0; i < 6; i++) passo(0, 1, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        segura(1, 4'b0010, 10);
        segura(1, 4'b0000, 8);
        // Two buttons: invalid, jogada keeps 0010.
        segura(1, 4'b0110, 10);
        segura(1, 4'b0000, 8);
        // Disabled: nothing happens.
        segura(0, 4'b0100, 10);
        segura(1, 4'b0000, 3);
        // Reset while filtering, then re-press.
        segura(1, 4'b1000, 3);
        passo(1, 1, 4'b1000);
        segura(1, 4'b0000, 3);
        segura(1, 4'b1000, 10);
        segura(1, 4'b0000, 8);
        // Held button detected right after reset without release.
        segura(1, 4'b0100, 2);
        passo(1, 1, 4'b0100);
        segura(1, 4'b0100, 8);
        segura(1, 4'b0000, 8);
        // Long hold, then second press after release.
        segura(1, 4'b0001, 4000);
        segura(1, 4'b0000, 5);
        segura(1, 4'b0001, 10);
        segura(1, 4'b0000, 8);
        // Release shorter than N is not a new press.
        segura(1, 4'b0010, 8);
        segura(1, 4'b0000, 3);
        segura(1, 4'b0010, 8);
        segura(1, 4'b0000, 8);
        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0:       v = 4'd0;
                1, 2:    v = 4'd1 << $urandom_range(0, 3);
                default: v = 4'($urandom_range(0, 15));
            endcase
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++)
                passo(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), v);
        end
        segura(1, 4'b0000, 12);
        vetores++;
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL fila_final got=%0d pending exp=0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 5, meaning consecutive stable samples required (legal 2..255; 5 cycles = 5 ms at 1 kHz).
REQ-002 SHALL have port clock  input  1  system clock; one clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port habilita  input  1  detection enable, driven by the game control unit.
REQ-005 SHALL have port botoes  input  4  raw player buttons, asynchronous to nothing (already clock-domain), possibly bouncing.
REQ-006 SHALL have port jogada_feita  output  1  one-cycle pulse, valid one-hot play captured.
REQ-007 SHALL have port jogada  output  4  registered one-hot play, valid while jogada_feita high and held afterwards.
REQ-008 SHALL have port jogada_invalida  output  1  one-cycle pulse, stable non-one-hot pattern captured.
REQ-009 SHALL have port db_estado  output  4  current FSM state code, for the 7-segment debug display.

Function
REQ-010 SHALL implement FSM states with codes: ESPERA=0, FILTRANDO=1, REGISTRA=2, INVALIDA=3, SOLTANDO=4; other codes unreachable, and the FSM SHALL recover to ESPERA from them.
REQ-011 SHALL, in ESPERA with habilita=1 and botoes!=0 at an edge, load amostra<=botoes, set cnt<=1 and go to FILTRANDO; otherwise stay in ESPERA.
REQ-012 SHALL, in FILTRANDO, on botoes==amostra increment cnt, and on reaching cnt==DEBOUNCE_CICLOS go to REGISTRA if amostra is one-hot, else INVALIDA.
REQ-013 SHALL, in FILTRANDO, on botoes!=amostra and botoes!=0 reload amostra<=botoes and cnt<=1 (stay); on botoes==0 or habilita=0 return to ESPERA.
REQ-014 SHALL load jogada<=amostra on the edge entering REGISTRA; jogada_feita=1 exactly during the REGISTRA cycle; next state SOLTANDO unconditionally.
REQ-015 SHALL assert jogada_invalida exactly during the INVALIDA cycle, leave jogada unchanged, next state SOLTANDO unconditionally.
REQ-016 SHALL, in SOLTANDO, count consecutive edges with botoes==0 and return to ESPERA when the count reaches DEBOUNCE_CICLOS; any botoes!=0 clears the count; habilita is ignored.
REQ-017 Latency: with botoes constant non-zero from sampling edge E0, jogada_feita SHALL be high in the cycle after edge E(DEBOUNCE_CICLOS-1) and low after E(DEBOUNCE_CICLOS).
REQ-018 SHALL produce at most one jogada_feita/jogada_invalida pulse per press, regardless of hold time; jogada_feita and jogada_invalida never high together.
REQ-019 cnt SHALL be $clog2(DEBOUNCE_CICLOS+1) bits, saturating, never wrapping.
REQ-020 Outputs jogada_feita, jogada_invalida, db_estado SHALL be decoded from the state register only (Moore, glitch-free).

Reset
REQ-021 reset=1 at an edge SHALL force state ESPERA, cnt=0, amostra=0, jogada=4'b0000, jogada_feita=0, jogada_invalida=0, db_estado=0, overriding all other inputs, including mid-filtering or mid-REGISTRA.
REQ-022 After reset, a button already held SHALL be detected as a new press only if habilita=1 (no release needed first).

Structure
REQ-023 State codes and DEBOUNCE_CICLOS default SHALL live in the shared game constants package, reused by circuito_exp5 debug decoding.
REQ-024 Stability counting SHALL use one sub-module contador_debounce (clear, enable, saturating count, fim flag) instantiated once, shared by FILTRANDO and SOLTANDO.

Verification
REQ-025 reset pulse, habilita=1, botoes=0001 held 10 cycles -> jogada_feita one pulse at 5th cycle after first sample, jogada=0001, db_estado 0->1->2->4->0.
REQ-026 botoes toggles 0001/0000 every cycle for 6 cycles then 0010 held 10 cycles -> single jogada_feita, jogada=0010.
REQ-027 botoes=0110 held 10 cycles -> one jogada_invalida pulse, no jogada_feita, jogada keeps previous value.
REQ-028 habilita=0, botoes=0100 held 10 cycles -> no pulses, db_estado stays 0.
REQ-029 botoes=1000 held 3 cycles then reset asserted one cycle while still held -> no pulse, all outputs zero; after release and re-press 10 cycles, jogada=1000.
REQ-030 botoes=0001 held 4000 cycles -> exactly one jogada_feita; second press after release of ≥5 cycles -> second pulse.
